mem_arbiter: RTL

Two-port arbiter and sequencer in front of the simulation memory model (combinational read, posedge write). It shares one memory port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write), using valid/ready request and response handshakes. It inserts a configurable access latency so the core is exercised against a multi-cycle memory. It sits between the core's IFU/LSU and the memory model instance in the simulation top.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (IFU/LSU) arbiter and latency sequencer in front of the simulation memory model.
// Optional MEM_ARB_RR_EN selects round-robin arbitration; by default the LSU has fixed priority.
module mem_arbiter #(
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        owner_reg, owner_next;
  logic [31:0] addr_reg, addr_next;
  logic        wen_reg, wen_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wmask_reg, wmask_next;
  logic [31:0] rdata_reg, rdata_next;

  logic        grant_lsu;
  logic        accept;

  assign accept = (state_reg == S_IDLE) && (ifu_req_valid || lsu_req_valid) && !rst;

`ifdef MEM_ARB_RR_EN
  logic last_grant_reg;

  // On contention the requester that was not served last wins.
  always_comb begin
    if (ifu_req_valid && lsu_req_valid) begin
      grant_lsu = (last_grant_reg == OWN_IFU);
    end else begin
      grant_lsu = lsu_req_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= OWN_IFU;
    end else if (accept) begin
      last_grant_reg <= grant_lsu;
    end
  end
`else
  assign grant_lsu = lsu_req_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      owner_reg <= OWN_IFU;
      addr_reg  <= RESET_ADDR;
      wen_reg   <= 1'b0;
      wdata_reg <= '0;
      wmask_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      owner_reg <= owner_next;
      addr_reg  <= addr_next;
      wen_reg   <= wen_next;
      wdata_reg <= wdata_next;
      wmask_reg <= wmask_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    owner_next     = owner_reg;
    addr_next      = addr_reg;
    wen_next       = wen_reg;
    wdata_next     = wdata_reg;
    wmask_next     = wmask_reg;
    rdata_next     = rdata_reg;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    mem_wen        = 1'b0;
    // Reset masks every strobe so a store in flight can never reach memory.
    if (!rst) begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            lsu_req_ready = grant_lsu;
            ifu_req_ready = !grant_lsu;
            owner_next    = grant_lsu ? OWN_LSU : OWN_IFU;
            addr_next     = grant_lsu ? lsu_req_addr : ifu_req_addr;
            wen_next      = grant_lsu && lsu_req_wen;
            wdata_next    = grant_lsu ? lsu_req_wdata : 32'h0;
            wmask_next    = grant_lsu ? lsu_req_wmask : 4'h0;
            cnt_next      = 8'(LATENCY - 1);
            state_next    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_reg != 8'd0) begin
            cnt_next = cnt_reg - 8'd1;
          end else begin
            mem_wen    = wen_reg;
            rdata_next = wen_reg ? 32'h0 : mem_rdata;
            state_next = S_RESP;
          end
        end
        S_RESP: begin
          ifu_resp_valid = (owner_reg == OWN_IFU);
          lsu_resp_valid = (owner_reg == OWN_LSU);
          if ((owner_reg == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready) begin
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign mem_raddr  = addr_reg;
  assign mem_waddr  = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign mem_wmask  = wmask_reg;
  assign resp_rdata = rdata_reg;

endmodule
